// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter. CPU stores to TXDATA push bytes into
//   a small TX FIFO; a serialiser drains the FIFO onto tx, LSB first.
//   Read data is zero whenever the window is not selected, so it can be ORed
//   with other read buses.
//
//   Register window (16 bytes at BASE_ADDR, word offsets):
//     0x0 TXDATA  W: push data[7:0] (byte lane 0). Reads 0.
//     0x4 STATUS  R: [15:8] fifo count, [3] ovf, [2] busy, [1] empty, [0] full.
//                 W: lane 0 with data[3]=1 clears ovf.
//     0x8 BAUDDIV R/W [15:0], clocks per bit, byte lanes 0/1; 0 is stored as 1.
//     0xC reserved (reads 0), or CTRL when MMIO_UART_TX_IRQ_EN is defined:
//                 bit0 = ie, and the irq output is present.
//
//   Ports:
//     clk           system clock, rising edge
//     resetn        asynchronous active-low reset
//     memAddress    byte address from CPU
//     memWriteData  store data
//     memWrite      store strobe
//     byteMask      byte-lane enables for stores
//     memReadData   registered read data, valid the cycle after the address
//     tx            serial output, idle high
//     irq           (MMIO_UART_TX_IRQ_EN only) ie & fifo empty & idle
//
//   Handshake: there is none -- stores complete in the cycle they are
//   presented, loads return data one cycle later, no wait states.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0200,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] memAddress,
    input  logic [31:0] memWriteData,
    input  logic        memWrite,
    input  logic [3:0]  byteMask,
    output logic [31:0] memReadData,
`ifdef MMIO_UART_TX_IRQ_EN
    output logic        irq,
`endif
    output logic        tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state, state_next;
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   fifo_cnt;
    logic [15:0]     baud_div, baud_new;
    logic [15:0]     bit_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            ovf;
    logic            sel, wr_sel, push_req, push_ok, full, empty, busy;
    logic            pop, reload, shift, bit_done, tx_next;
    logic [1:0]      offset;
    logic [31:0]     rd_data;

    logic unused_bits;
    assign unused_bits = ^{memWriteData[31:16], memAddress[1:0]};

    // ---------------------------------------------------------------- decode
    assign sel      = (memAddress[31:4] == BASE_ADDR[31:4]);
    assign offset   = memAddress[3:2];
    assign wr_sel   = sel & memWrite;
    assign push_req = wr_sel & (offset == 2'd0) & byteMask[0];
    assign full     = (fifo_cnt == CW'(FIFO_DEPTH));
    assign empty    = (fifo_cnt == '0);
    // Fullness is judged before any same-cycle pop, so a push into a full
    // FIFO is always dropped.
    assign push_ok  = push_req & ~full;
    assign busy     = (state != S_IDLE);
    assign bit_done = (bit_cnt == 16'd0);

    // ------------------------------------------------------------ FSM: state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    // ------------------------------------------------------- FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (!empty) state_next = S_START;
            S_START: if (bit_done) state_next = S_DATA;
            S_DATA:  if (bit_done && bit_idx == 3'd7) state_next = S_STOP;
            S_STOP:  if (bit_done) state_next = empty ? S_IDLE : S_START;
            default: state_next = S_IDLE;
        endcase
    end

    // ----------------------------------------------------------- FSM: outputs
    always_comb begin
        pop     = 1'b0;
        shift   = 1'b0;
        reload  = 1'b0;
        tx_next = 1'b1;
        case (state)
            S_IDLE:  pop = ~empty;
            S_START: begin
                tx_next = 1'b0;
                reload  = bit_done;
            end
            S_DATA: begin
                tx_next = shreg[0];
                reload  = bit_done;
                shift   = bit_done & (bit_idx != 3'd7);
            end
            S_STOP:  pop = bit_done & ~empty;
            default: ;
        endcase
        if (pop) reload = 1'b1;
    end

    // ------------------------------------------------------- serialiser path
    // bit_cnt is reloaded from the live BAUDDIV at every bit start, so a
    // divisor change takes effect at the next bit boundary.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
            tx      <= 1'b1;
        end else begin
            tx <= tx_next;  // registered, so tx lags the state by one clock
            if (reload)          bit_cnt <= baud_div - 16'd1;
            else if (!bit_done)  bit_cnt <= bit_cnt - 16'd1;
            if (pop) begin
                shreg   <= fifo_mem[rd_ptr];
                bit_idx <= 3'd0;
            end else if (shift) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------ FIFO
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= memWriteData[7:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------- registers
    always_comb begin
        baud_new = baud_div;
        if (byteMask[0]) baud_new[7:0]  = memWriteData[7:0];
        if (byteMask[1]) baud_new[15:8] = memWriteData[15:8];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            baud_div <= DEFAULT_DIV;
            ovf      <= 1'b0;
        end else begin
            if (wr_sel && offset == 2'd2 && (|byteMask[1:0]))
                baud_div <= (baud_new == 16'd0) ? 16'd1 : baud_new;
            if (push_req && full)
                ovf <= 1'b1;
            else if (wr_sel && offset == 2'd1 && byteMask[0] && memWriteData[3])
                ovf <= 1'b0;
        end
    end

`ifdef MMIO_UART_TX_IRQ_EN
    logic ie;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ie  <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (wr_sel && offset == 2'd3 && byteMask[0]) ie <= memWriteData[0];
            irq <= ie & empty & ~busy;
        end
    end
`endif

    // ------------------------------------------------------------ read path
    always_comb begin
        rd_data = 32'd0;
        case (offset)
            2'd1: rd_data = {16'd0, 8'(fifo_cnt), 4'd0, ovf, busy, empty, full};
            2'd2: rd_data = {16'd0, baud_div};
`ifdef MMIO_UART_TX_IRQ_EN
            2'd3: rd_data = {31'd0, ie};
`endif
            default: rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) memReadData <= 32'd0;
        else         memReadData <= sel ? rd_data : 32'd0;
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] memAddress = '0;
  logic [31:0] memWriteData = '0;
  logic        memWrite = 1'b0;
  logic [3:0]  byteMask = '0;
  logic [31:0] memReadData;
  logic        tx;
`ifdef MMIO_UART_TX_IRQ_EN
  logic        irq;
`endif

  mmio_uart_tx dut (
    .clk(clk),
    .resetn(resetn),
    .memAddress(memAddress),
    .memWriteData(memWriteData),
    .memWrite(memWrite),
    .byteMask(byteMask),
    .memReadData(memReadData),
`ifdef MMIO_UART_TX_IRQ_EN
    .irq(irq),
`endif
    .tx(tx)
  );

  // ---------------------------------------------------------- clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- scoreboard
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         mon_div = 868;

  // Line monitor: decodes 8N1 frames from tx, sampling every clock, and
  // requires each bit to hold its level for exactly mon_div clocks.
  initial begin : monitor
    int         st;
    logic [7:0] data;
    logic [7:0] exp;
    logic       ok;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (resetn && tx === 1'b0) begin
        st = cyc; ok = 1'b1; aborted = 1'b0; data = '0;
        for (int k = 1; k < mon_div; k++) begin
          @(negedge clk);
          if (!resetn) aborted = 1'b1;
          if (tx !== 1'b0) ok = 1'b0;
        end
        for (int b = 0; b < 8; b++) begin
          @(negedge clk);
          if (!resetn) aborted = 1'b1;
          data[b] = tx;
          for (int k = 1; k < mon_div; k++) begin
            @(negedge clk);
            if (!resetn) aborted = 1'b1;
            if (tx !== data[b]) ok = 1'b0;
          end
        end
        for (int k = 0; k < mon_div; k++) begin
          @(negedge clk);
          if (!resetn) aborted = 1'b1;
          if (tx !== 1'b1) ok = 1'b0;
        end
        if (!aborted) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL frame_unexpected got=%02h expected=none", data);
          end else begin
            exp = exp_q.pop_front();
            if (!ok || data !== exp) begin
              failures++;
              $display("FAIL frame got=%02h shape_ok=%0b expected=%02h shape_ok=1", data, ok, exp);
            end
          end
          start_q.push_back(st);
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    memAddress = a; memWriteData = d; byteMask = m; memWrite = 1'b1;
    @(posedge clk);
  endtask

  task automatic bus_idle();
    @(negedge clk);
    memWrite = 1'b0; byteMask = '0; memAddress = '0; memWriteData = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    memWrite = 1'b0; byteMask = '0; memAddress = a;
    @(posedge clk);
    @(negedge clk);
    d = memReadData;
    memAddress = '0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout frames_left=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    logic [31:0] r;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b expected=1", tx); end
    checks++;
    if (memReadData !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h expected=0", memReadData); end
    resetn = 1'b1;
    bus_read(32'h204, r);
    checks++;
    if (r !== 32'h2) begin failures++; $display("FAIL reset_status got=%h expected=2", r); end
    bus_read(32'h208, r);
    checks++;
    if (r !== 32'd868) begin failures++; $display("FAIL reset_baud got=%0d expected=868", r); end
    bus_read(32'h20C, r);
    checks++;
    if (r !== 32'd0) begin failures++; $display("FAIL reset_reg_c got=%h expected=0", r); end
  endtask

  task automatic test_regs();
    logic [31:0] r;
    bus_write(32'h208, 32'h0, 4'b0011);
    bus_read(32'h208, r);
    checks++;
    if (r !== 32'd1) begin failures++; $display("FAIL baud_zero got=%h expected=1", r); end
    bus_write(32'h208, 32'hDEAD_1234, 4'b1111);
    bus_read(32'h208, r);
    checks++;
    if (r !== 32'h1234) begin failures++; $display("FAIL baud_full got=%h expected=1234", r); end
    bus_write(32'h208, 32'hFFFF_AB00, 4'b0010);
    bus_read(32'h208, r);
    checks++;
    if (r !== 32'hAB34) begin failures++; $display("FAIL baud_lane1 got=%h expected=ab34", r); end
    bus_write(32'h208, 32'h0000_0000, 4'b0001);
    bus_read(32'h208, r);
    checks++;
    if (r !== 32'hAB00) begin failures++; $display("FAIL baud_lane0 got=%h expected=ab00", r); end
    bus_read(32'h100, r);
    checks++;
    if (r !== 32'd0) begin failures++; $display("FAIL unselected_read got=%h expected=0", r); end
    bus_write(32'h20C, 32'hFFFF_FFFF, 4'b1111);
    bus_read(32'h20C, r);
`ifdef MMIO_UART_TX_IRQ_EN
    checks++;
    if (r !== 32'd1) begin failures++; $display("FAIL ctrl_rw got=%h expected=1", r); end
    bus_write(32'h20C, 32'h0, 4'b0001);
`else
    checks++;
    if (r !== 32'd0) begin failures++; $display("FAIL reserved_read got=%h expected=0", r); end
`endif
    // A store just past the window must not reach the FIFO.
    bus_write(32'h210, 32'h0000_00AA, 4'b1111);
    bus_read(32'h204, r);
    checks++;
    if (r !== 32'h2) begin failures++; $display("FAIL outside_store_status got=%h expected=2", r); end
  endtask

  task automatic test_single();
    logic [31:0] r;
    int          push_cyc;
    bus_write(32'h208, 32'd4, 4'b0011);
    mon_div = 4;
    start_q.delete();
    exp_q.push_back(8'h55);
    bus_write(32'h200, 32'h0000_0055, 4'b0001);
    bus_idle();
    push_cyc = cyc;
    bus_read(32'h204, r);
    checks++;
    if (r !== 32'h6) begin failures++; $display("FAIL single_status_busy got=%h expected=6", r); end
    wait_drain(200);
    checks++;
    if (start_q.size() != 1 || start_q[0] - push_cyc != 2) begin
      failures++;
      $display("FAIL single_start_latency frames=%0d delay=%0d expected frames=1 delay=2",
               start_q.size(), (start_q.size() > 0) ? start_q[0] - push_cyc : -1);
    end
    bus_read(32'h204, r);
    checks++;
    if (r !== 32'h2) begin failures++; $display("FAIL single_status_idle got=%h expected=2", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [7:0]  b;
    int          n, acc;
    logic        gap_bad;
    bus_write(32'h208, 32'd2, 4'b0011);
    mon_div = 2;
    for (int it = 0; it < 5; it++) begin
      n = (it == 0) ? 10 : $urandom_range(1, 12);
      acc = 0;
      bus_write(32'h204, 32'h8, 4'b0001);
      start_q.delete();
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        // One byte moves straight into the shifter, then DEPTH more fit
        // before the first frame (20 clocks) finishes.
        if (i < DEPTH + 1) begin
          exp_q.push_back(b);
          acc++;
        end
        bus_write(32'h200, {8'($urandom), 8'($urandom), 8'($urandom), b},
                  4'b0001 | 4'($urandom_range(0, 15)));
      end
      bus_idle();
      bus_read(32'h204, r);
      checks++;
      if (r[15:8] !== 8'(acc - 1) || r[3] !== (n > DEPTH + 1) || r[0] !== (acc - 1 == DEPTH)) begin
        failures++;
        $display("FAIL burst_status n=%0d got cnt=%0d ovf=%b full=%b expected cnt=%0d ovf=%b full=%b",
                 n, r[15:8], r[3], r[0], acc - 1, (n > DEPTH + 1), (acc - 1 == DEPTH));
      end
      wait_drain(400);
      gap_bad = (start_q.size() != acc);
      for (int k = 1; k < start_q.size(); k++)
        if (start_q[k] - start_q[k-1] != 20) gap_bad = 1'b1;
      checks++;
      if (gap_bad) begin
        failures++;
        $display("FAIL burst_spacing n=%0d frames=%0d expected frames=%0d spacing=20", n, start_q.size(), acc);
      end
    end
  endtask

  task automatic test_status_ovf();
    logic [31:0] r;
    logic [7:0]  b;
    bus_write(32'h208, 32'd50, 4'b0011);
    mon_div = 50;
    bus_write(32'h204, 32'h8, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      bus_write(32'h200, {24'd0, b}, 4'b0001);
    end
    bus_read(32'h204, r);
    checks++;
    if (r[15:8] !== 8'd3 || r[1:0] !== 2'b00 || r[3] !== 1'b0) begin
      failures++;
      $display("FAIL status_cnt3 got=%h expected cnt=3 ovf=0 empty=0 full=0", r);
    end
    for (int i = 4; i < 10; i++) begin
      b = 8'($urandom);
      if (i < DEPTH + 1) exp_q.push_back(b);
      bus_write(32'h200, {24'd0, b}, 4'b0001);
    end
    bus_read(32'h204, r);
    checks++;
    if (r !== 32'h0000_080D) begin failures++; $display("FAIL status_full_ovf got=%h expected=0000080d", r); end
    bus_write(32'h204, 32'h8, 4'b0001);
    bus_read(32'h204, r);
    checks++;
    if (r !== 32'h0000_0805) begin failures++; $display("FAIL status_ovf_clear got=%h expected=00000805", r); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] r;
    logic        tx_low;
    repeat (100) @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL midreset_tx got=%b expected=1", tx); end
    exp_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    bus_read(32'h204, r);
    checks++;
    if (r !== 32'h2) begin failures++; $display("FAIL midreset_status got=%h expected=2", r); end
    bus_read(32'h208, r);
    checks++;
    if (r !== 32'd868) begin failures++; $display("FAIL midreset_baud got=%0d expected=868", r); end
    tx_low = 1'b0;
    repeat (600) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_low = 1'b1;
    end
    checks++;
    if (tx_low) begin failures++; $display("FAIL midreset_tx_idle got=low expected=high"); end
  endtask

`ifdef MMIO_UART_TX_IRQ_EN
  task automatic test_irq();
    logic [31:0] r;
    logic        irq_hi;
    bus_write(32'h208, 32'd3, 4'b0011);
    mon_div = 3;
    bus_write(32'h20C, 32'h1, 4'b0001);
    bus_read(32'h20C, r);
    checks++;
    if (r !== 32'd1) begin failures++; $display("FAIL irq_ctrl got=%h expected=1", r); end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_idle got=%b expected=1", irq); end
    exp_q.push_back(8'hA5);
    bus_write(32'h200, 32'hA5, 4'b0001);
    bus_idle();
    @(negedge clk);
    irq_hi = 1'b0;
    repeat (20) begin
      if (irq !== 1'b0) irq_hi = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (irq_hi) begin failures++; $display("FAIL irq_during_frame got=1 expected=0"); end
    wait_drain(200);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_after_frame got=%b expected=1", irq); end
    bus_write(32'h20C, 32'h0, 4'b0001);
    bus_idle();
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_disabled got=%b expected=0", irq); end
  endtask
`endif

  // ------------------------------------------------------------------ main
  initial begin
    test_reset();
    test_regs();
    test_single();
    test_back_to_back();
    test_status_ovf();
    test_reset_mid_frame();
`ifdef MMIO_UART_TX_IRQ_EN
    test_irq();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
